// File: rtl/pwm_modulator.sv
// Sine-sample driven PWM modulator with complementary gate outputs and dead-time insertion.
// A one-entry sample buffer feeds the duty register once per period (or at once while idle).
module pwm_modulator #(
    parameter int CNT_W     = 10,
    parameter int DEADTIME  = 4,
    parameter bit SIGNED_IN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [15:0]      sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pwm_hi,
    output logic             pwm_lo,
    output logic             period_start,
    output logic [CNT_W-1:0] duty_q,
    output logic             underrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       DT_INIT = 4'(DEADTIME);

    logic [CNT_W-1:0] cnt_p0;
    logic [15:0]      buf_q;
    logic             buf_full;
    logic             accept;
    logic             at_wrap;
    logic             load;
    logic             raw_p0;
    logic             raw_p1;
    logic             changed;
    logic [3:0]       dt_cnt;
    logic [3:0]       dt_next;
    logic             blocked;

    // Offset-binary conversion followed by truncation to the counter width.
    function automatic logic [CNT_W-1:0] conv(input logic [15:0] s);
        logic [15:0] u;
        u = SIGNED_IN ? (s ^ 16'h8000) : s;
        return CNT_W'(u >> (16 - CNT_W));
    endfunction

    assign sample_ready = !buf_full && !reset;
    assign accept       = sample_valid && sample_ready;
    assign at_wrap      = en && (cnt_p0 == CNT_MAX);
    assign load         = at_wrap || (!en && buf_full);
    assign underrun     = !reset && at_wrap && !buf_full;
    assign period_start = !reset && en && (cnt_p0 == '0);

    // Stage p0: raw comparator and dead-time bookkeeping
    assign raw_p0  = en && (cnt_p0 < duty_q);
    assign changed = raw_p0 != raw_p1;
    assign dt_next = changed ? DT_INIT : ((dt_cnt != 4'd0) ? dt_cnt - 4'd1 : 4'd0);
    assign blocked = dt_next != 4'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p0   <= '0;
            duty_q   <= '0;
            buf_full <= 1'b0;
            raw_p1   <= 1'b0;
            dt_cnt   <= DT_INIT;
            pwm_hi   <= 1'b0;
            pwm_lo   <= 1'b0;
        end else begin
            cnt_p0 <= en ? cnt_p0 + CNT_W'(1) : '0;
            if (load && buf_full) begin
                duty_q   <= conv(buf_q);
                buf_full <= 1'b0;
            end else if (accept) begin
                buf_full <= 1'b1;
            end
            // Stage p1: registered gate drives, low-side also gated by en
            raw_p1 <= raw_p0;
            dt_cnt <= dt_next;
            pwm_hi <= raw_p0 && !blocked;
            pwm_lo <= en && !raw_p0 && !blocked;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q <= sample_in;
        end
    end

endmodule

// File: tb/tb_pwm_modulator.sv
// Directed bench for pwm_modulator at CNT_W=10, DEADTIME=4, SIGNED_IN=1.
// Inputs change 1 ns after the falling edge; outputs are sampled 1-2 ns after it.
module tb_pwm_modulator;

    logic       clk;
    logic       reset;
    logic       en;
    logic [15:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       pwm_hi;
    logic       pwm_lo;
    logic       period_start;
    logic [9:0] duty_q;
    logic       underrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hi_n   = 0;
    int lo_n   = 0;
    int bl_n   = 0;

    pwm_modulator #(.CNT_W(10), .DEADTIME(4), .SIGNED_IN(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pwm_hi       (pwm_hi),
        .pwm_lo       (pwm_lo),
        .period_start (period_start),
        .duty_q       (duty_q),
        .underrun     (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n falling edges, tallying output levels and checking for shoot-through.
    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            cyc++;
            if (pwm_hi) hi_n++;
            if (pwm_lo) lo_n++;
            if (!pwm_hi && !pwm_lo) bl_n++;
            chk("no_overlap", {31'd0, pwm_hi & pwm_lo}, 32'd0);
        end
    endtask

    task automatic goto(input int k);
        adv(k - cyc);
    endtask

    task automatic clear_counts();
        hi_n = 0;
        lo_n = 0;
        bl_n = 0;
    endtask

    initial begin
        reset        = 1'b1;
        en           = 1'b0;
        sample_valid = 1'b0;
        sample_in    = 16'h0000;
        repeat (3) @(negedge clk);
        #1;
        sample_valid = 1'b1;
        sample_in    = 16'h1234;
        #1;
        chk("rst_ready", sample_ready, 0);
        chk("rst_hi", pwm_hi, 0);
        chk("rst_lo", pwm_lo, 0);
        chk("rst_duty", duty_q, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_underrun", underrun, 0);
        @(negedge clk);
        #1;

        // Release reset with sample 0x0000 -> duty 512 after the first wrap
        reset     = 1'b0;
        en        = 1'b1;
        sample_in = 16'h0000;
        cyc       = 0;
        #1;
        chk("ps_first", period_start, 1);
        chk("ready_first", sample_ready, 1);
        goto(1);
        sample_valid = 1'b0;
        #1;
        chk("ready_full", sample_ready, 0);
        chk("duty_before_wrap", duty_q, 0);
        goto(3);
        chk("lo_dead_after_reset", pwm_lo, 0);
        goto(4);
        chk("lo_after_dead", pwm_lo, 1);
        goto(1023);
        chk("no_underrun_when_full", underrun, 0);
        goto(1024);
        chk("duty_512", duty_q, 512);
        chk("ps_wrap", period_start, 1);
        chk("ready_after_load", sample_ready, 1);
        clear_counts();
        goto(1028);
        chk("hi_dead_rise", pwm_hi, 0);
        goto(1029);
        chk("hi_after_dead", pwm_hi, 1);

        // No sample in this period: underrun at cnt=1023, same-cycle sample held
        goto(2046);
        chk("underrun_early", underrun, 0);
        goto(2047);
        sample_valid = 1'b1;
        sample_in    = 16'h8000;
        #1;
        chk("underrun_pulse", underrun, 1);
        chk("ready_at_underrun", sample_ready, 1);
        goto(2048);
        sample_valid = 1'b0;
        #1;
        chk("underrun_end", underrun, 0);
        chk("duty_kept", duty_q, 512);
        chk("ready_held", sample_ready, 0);
        chk("ps_2048", period_start, 1);
        chk("hi_cycles_512", hi_n, 508);
        chk("lo_cycles_512", lo_n, 508);
        chk("both_low_512", bl_n, 8);

        // Held 0x8000 loads at the next wrap -> duty 0; then A=0x7FFF, B=0x4000
        goto(3072);
        chk("duty_0", duty_q, 0);
        chk("ps_3072", period_start, 1);
        sample_valid = 1'b1;
        sample_in    = 16'h7FFF;
        #1;
        chk("ready_a", sample_ready, 1);
        clear_counts();
        goto(3073);
        sample_in = 16'h4000;
        #1;
        chk("ready_b_blocked", sample_ready, 0);
        goto(4095);
        chk("ready_b_still_blocked", sample_ready, 0);
        chk("duty_0_end", duty_q, 0);
        chk("underrun_none_4095", underrun, 0);
        goto(4096);
        chk("hi_cycles_0", hi_n, 0);
        chk("lo_cycles_0", lo_n, 1024);
        chk("duty_a", duty_q, 1023);
        chk("ready_b_open", sample_ready, 1);
        clear_counts();
        goto(4097);
        sample_valid = 1'b0;
        #1;
        chk("ready_b_taken", sample_ready, 0);
        chk("duty_a_held", duty_q, 1023);
        goto(5120);
        chk("hi_cycles_1023", hi_n, 1019);
        chk("lo_cycles_1023", lo_n, 0);
        chk("duty_b", duty_q, 768);
        chk("hi_low_wrap", pwm_hi, 0);
        goto(5124);
        chk("hi_low_5th", pwm_hi, 0);
        goto(5125);
        chk("hi_back", pwm_hi, 1);

        // Buffer a sample, then reset at cnt=300 while pwm_hi=1
        sample_valid = 1'b1;
        sample_in    = 16'h7FFF;
        goto(5126);
        sample_valid = 1'b0;
        #1;
        chk("ready_c_taken", sample_ready, 0);
        goto(5420);
        chk("hi_before_reset", pwm_hi, 1);
        reset = 1'b1;
        #1;
        chk("ready_in_reset", sample_ready, 0);
        chk("ps_in_reset", period_start, 0);
        chk("underrun_in_reset", underrun, 0);
        goto(5421);
        chk("hi_after_reset", pwm_hi, 0);
        chk("lo_after_reset", pwm_lo, 0);
        chk("duty_after_reset", duty_q, 0);
        goto(5422);
        reset = 1'b0;
        #1;
        chk("ps_after_release", period_start, 1);
        chk("buffer_discarded", sample_ready, 1);
        chk("duty_release", duty_q, 0);
        goto(5425);
        chk("lo_dead_release", pwm_lo, 0);
        goto(5426);
        chk("lo_after_release", pwm_lo, 1);

        // en=0: outputs drop next cycle, buffer loads immediately
        en           = 1'b0;
        sample_valid = 1'b1;
        sample_in    = 16'h0000;
        #1;
        chk("ready_idle", sample_ready, 1);
        chk("ps_idle", period_start, 0);
        goto(5427);
        sample_valid = 1'b0;
        #1;
        chk("hi_idle", pwm_hi, 0);
        chk("lo_idle", pwm_lo, 0);
        chk("ready_idle_full", sample_ready, 0);
        chk("underrun_idle", underrun, 0);
        chk("duty_idle_pre", duty_q, 0);
        goto(5428);
        chk("duty_idle_load", duty_q, 512);
        chk("ready_idle_empty", sample_ready, 1);
        chk("ps_idle_cnt0", period_start, 0);
        en = 1'b1;
        #1;
        chk("ps_reenable", period_start, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_modulator.md
PWM_MODULATOR -- requirements
Module: pwm_modulator

Interface
REQ-001 Parameter CNT_W, default 10: PWM counter width; period = 2^CNT_W clocks.
REQ-002 Parameter DEADTIME, default 4: clocks of both-outputs-low after each raw PWM transition; legal range 0..15.
REQ-003 Parameter SIGNED_IN, default 1: 1 = sample_in is two's complement, 0 = offset binary.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  run enable.
REQ-007 sample_in  input  16  sine sample from the DDS stage.
REQ-008 sample_valid  input  1  sample_in is valid this cycle.
REQ-009 sample_ready  output  1  one-entry buffer can accept a sample.
REQ-010 pwm_hi  output  1  high-side gate drive, registered.
REQ-011 pwm_lo  output  1  low-side gate drive, complementary to pwm_hi, registered.
REQ-012 period_start  output  1  one-cycle pulse at counter value 0.
REQ-013 duty_q  output  CNT_W  active duty value.
REQ-014 underrun  output  1  one-cycle pulse, no buffered sample at a load event.

Function
REQ-015 Counter cnt increments by 1 each cycle while en=1 and wraps from 2^CNT_W-1 to 0; held at 0 while en=0.
REQ-016 period_start = 1 for exactly the cycles where en=1 and cnt=0.
REQ-017 Buffer: sample accepted when sample_valid and sample_ready are both 1; sample_ready = !buf_full and !reset.
REQ-018 Load event: en=1 and cnt=2^CNT_W-1, or en=0 and buf_full; the new duty_q takes effect on the following cycle (cnt=0).
REQ-019 At a load event with buf_full=1: duty_q <= conv(buffer), buf_full cleared in the same cycle.
REQ-020 At a load event with en=1 and buf_full=0: duty_q retained and underrun pulses for one cycle; a sample accepted in that same cycle is held until the next load event.
REQ-021 conv: u = sample_in XOR 0x8000 if SIGNED_IN=1, else u = sample_in; duty = u[15:16-CNT_W], truncated with no rounding.
REQ-022 raw = en and (cnt < duty_q); duty 0 gives raw always low; duty 2^CNT_W-1 gives raw low for 1 cycle per period.
REQ-023 Dead time: after any change of raw, both outputs are low from the first change until DEADTIME clocks after the most recent change; after that, pwm_hi = raw and pwm_lo = !raw.
REQ-024 Output latency: with DEADTIME=0, pwm_hi and pwm_lo equal raw and !raw delayed by 1 clock.
REQ-025 A raw phase shorter than DEADTIME never asserts its output.
REQ-026 pwm_hi and pwm_lo are never both 1 in any cycle, including during reset and en transitions.
REQ-027 en=0: pwm_hi=0 and pwm_lo=0 on the next cycle; the buffer still accepts samples.

Reset
REQ-028 While reset=1: cnt=0, duty_q=0, buf_full=0, sample_ready=0, pwm_hi=0, pwm_lo=0, period_start=0, underrun=0, and the dead-time counter is loaded with DEADTIME.
REQ-029 Reset asserted mid-period aborts the period; outputs are 0 from the cycle after reset is sampled; a buffered sample is discarded.
REQ-030 After reset release, both outputs stay low for at least DEADTIME clocks.

Verification (CNT_W=10, DEADTIME=4, SIGNED_IN=1)
REQ-031 Reset, en=1, sample 0x0000 -> duty_q=512 after the next wrap; per period, pwm_hi high for 508 cycles, pwm_lo high for 508 cycles, 4 cycles both low at each edge.
REQ-032 Sample 0x8000 -> duty_q=0; pwm_hi never 1; pwm_lo continuously 1 after the dead time.
REQ-033 Sample 0x7FFF -> duty_q=1023; pwm_lo never 1; pwm_hi low for 5 cycles per period.
REQ-034 No sample supplied before a wrap -> underrun pulses once at cnt=1023; duty_q unchanged.
REQ-035 Two consecutive valid samples A, B -> A accepted, sample_ready=0 until the wrap loads A, then B is accepted; duty sequence is A then B.
REQ-036 Reset pulsed at cnt=300 while pwm_hi=1 -> pwm_hi=0 on the next cycle, sample_ready=0 during reset, cnt=0 after release.
